// File: rtl/branch_outcome_queue.sv
// Queue of outstanding branch predictions, retired in order by resolves from execute.
// Compares each resolved direction against its prediction, flushes on mispredict and counts misses.
module branch_outcome_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pred_valid,
  input  logic                     pred_taken,
  input  logic                     resolve_valid,
  input  logic                     resolve_taken,
  output logic                     result,
  output logic                     taken,
  output logic                     mispredict,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_W-1:0]         mispredict_cnt,
  output logic                     overflow_err,
  output logic                     underflow_err
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   OCC_ONE  = 1;
  localparam logic [PW:0]   OCC_MAX  = DEPTH[PW:0];
  localparam logic [PW-1:0] PTR_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [DEPTH-1:0] entries;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      occ;

  logic head;
  logic resolve_ok;
  logic miss;
  logic push_ok;

  assign count = occ;
  assign full  = (occ == OCC_MAX);
  assign empty = (occ == '0);

  assign head       = entries[rd_ptr];
  assign resolve_ok = resolve_valid && !empty;
  assign miss       = resolve_ok && (head != resolve_taken);
  // A mispredict makes everything younger wrong-path, including a prediction arriving now.
  assign push_ok    = pred_valid && (!full || resolve_ok) && !miss;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entries <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
    end else if (miss) begin
      rd_ptr <= wr_ptr;
      occ    <= '0;
    end else begin
      if (push_ok) begin
        entries[wr_ptr] <= pred_taken;
        wr_ptr          <= wr_ptr + PTR_ONE;
      end
      if (resolve_ok)
        rd_ptr <= rd_ptr + PTR_ONE;
      if (push_ok && !resolve_ok)
        occ <= occ + OCC_ONE;
      else if (resolve_ok && !push_ok)
        occ <= occ - OCC_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result     <= 1'b0;
      taken      <= 1'b0;
      mispredict <= 1'b0;
    end else begin
      result     <= resolve_ok;
      mispredict <= miss;
      if (resolve_ok)
        taken <= resolve_taken;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mispredict_cnt <= '0;
      overflow_err   <= 1'b0;
      underflow_err  <= 1'b0;
    end else begin
      if (miss && (mispredict_cnt != '1))
        mispredict_cnt <= mispredict_cnt + CNT_ONE;
      if (pred_valid && full && !resolve_ok)
        overflow_err <= 1'b1;
      if (resolve_valid && empty)
        underflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_outcome_queue.sv
// Scoreboarded bench for branch_outcome_queue: a queue-based reference model predicts
// every result strobe and the status outputs; a monitor compares after each rising edge.
module tb_branch_outcome_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pred_valid = 1'b0, pred_taken = 1'b0, resolve_valid = 1'b0, resolve_taken = 1'b0;
  logic result, taken, mispredict, full, empty, overflow_err, underflow_err;
  logic [$clog2(DEPTH):0] count;
  logic [CNT_W-1:0] mispredict_cnt;

  branch_outcome_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .result(result), .taken(taken), .mispredict(mispredict),
    .full(full), .empty(empty), .count(count),
    .mispredict_cnt(mispredict_cnt),
    .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  // Reference model: the queue of outstanding predictions plus expected outcomes.
  bit        m_q[$];
  bit [1:0]  exp_q[$];   // {taken, mispredict} per accepted resolve
  bit        m_over, m_under, exp_result;
  int        m_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    m_over = 0; m_under = 0; exp_result = 0; m_cnt = 0;
  endtask

  // Drive one cycle of inputs at the falling edge and advance the model to the next rising edge.
  task automatic step(input bit pv, input bit pt, input bit rv, input bit rt);
    bit acc, mis, was_full;
    @(negedge clk);
    pred_valid = pv; pred_taken = pt; resolve_valid = rv; resolve_taken = rt;
    was_full = (m_q.size() == DEPTH);
    acc = rv && (m_q.size() > 0);
    mis = acc && (m_q[0] != rt);
    if (rv && m_q.size() == 0) m_under = 1;
    if (pv && was_full && !acc) m_over = 1;
    exp_result = acc;
    if (acc) begin
      exp_q.push_back({rt, mis});
      void'(m_q.pop_front());
      if (mis) begin
        m_q.delete();
        if (m_cnt < CNT_MAX) m_cnt++;
      end
    end
    if (pv && !mis && (!was_full || acc)) m_q.push_back(pt);
  endtask

  function automatic bit head_dir();
    return (m_q.size() > 0) ? m_q[0] : 1'b0;
  endfunction

  task automatic resolve_ok(input bit pv, input bit pt);
    step(pv, pt, 1'b1, head_dir());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  // Asynchronous reset between edges, with a stale resolve pending on the inputs.
  task automatic async_reset();
    @(negedge clk);
    pred_valid = 0; resolve_valid = 1; resolve_taken = 1;
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_over", overflow_err, 0);
    check("rst_under", underflow_err, 0);
    check("rst_result", result, 0);
    check("rst_misp", mispredict, 0);
    check("rst_mcnt", mispredict_cnt, 0);
    check("rst_taken", taken, 0);
    @(negedge clk);
    rst = 1'b0;
    resolve_valid = 0;
    exp_result = 0;
  endtask

  // Monitor: compare DUT against the model just after every rising edge.
  initial begin
    bit [1:0] e;
    forever begin
      @(posedge clk);
      #1;
      check("count", count, m_q.size());
      check("full", full, m_q.size() == DEPTH);
      check("empty", empty, m_q.size() == 0);
      check("overflow_err", overflow_err, m_over);
      check("underflow_err", underflow_err, m_under);
      check("mispredict_cnt", mispredict_cnt, m_cnt);
      check("result", result, exp_result);
      if (result) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("taken", taken, e[1]);
          check("mispredict", mispredict, e[0]);
        end
      end else begin
        check("mispredict_idle", mispredict, 0);
      end
    end
  end

  initial begin
    model_reset();
    #12;
    @(negedge clk);
    rst = 1'b0;

    // In-order correct resolves
    step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 0);
    step(0, 0, 1, 1); step(0, 0, 1, 0); step(0, 0, 1, 1);
    idle(2);

    // Mispredict flushes younger entries; a later resolve underflows
    step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    idle(1);
    step(0, 0, 1, 0);
    idle(1);
    async_reset();

    // Overfill, then drain
    for (int i = 0; i < 5; i++) step(1, 1'($urandom_range(0, 1)), 0, 0);
    for (int i = 0; i < 4; i++) resolve_ok(0, 0);
    idle(1);
    async_reset();

    // Full queue with simultaneous push and correct resolve
    for (int i = 0; i < 4; i++) step(1, 1'($urandom_range(0, 1)), 0, 0);
    resolve_ok(1, 1'b1);
    for (int i = 0; i < 4; i++) resolve_ok(0, 0);
    idle(1);
    async_reset();

    // Saturate the mispredict counter
    for (int i = 0; i < 260; i++) begin
      step(1, 1, 0, 0);
      step(1, 1, 1, 0);
    end
    idle(1);
    check("mcnt_saturated", mispredict_cnt, CNT_MAX);
    async_reset();

    // Async reset with three queued entries
    step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 0);
    async_reset();
    idle(2);

    // Random traffic, mostly correct resolves
    for (int i = 0; i < 3000; i++) begin
      bit pv, pt, rv, rt;
      pv = ($urandom_range(0, 99) < 55);
      pt = 1'($urandom_range(0, 1));
      rv = ($urandom_range(0, 99) < 45);
      rt = ($urandom_range(0, 9) < 8) ? head_dir() : 1'($urandom_range(0, 1));
      step(pv, pt, rv, rt);
      if (i == 1500) async_reset();
    end
    idle(3);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_outcome_queue.md
BRANCH_OUTCOME_QUEUE -- requirements
Module: branch_outcome_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of outstanding predictions held; SHALL be a power of two, 2..16.
REQ-002 Parameter CNT_W, default 8, width of the misprediction counter.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 pred_valid  input  1  predictor issued a prediction this cycle.
REQ-006 pred_taken  input  1  predicted direction (1 = taken).
REQ-007 resolve_valid  input  1  execute stage resolved the oldest outstanding branch.
REQ-008 resolve_taken  input  1  actual direction of that branch.
REQ-009 result  output  1  one-cycle update strobe to the predictor's result input.
REQ-010 taken  output  1  actual direction accompanying result.
REQ-011 mispredict  output  1  one-cycle pulse: resolved direction differed from queued prediction.
REQ-012 full  output  1  occupancy == DEPTH.
REQ-013 empty  output  1  occupancy == 0.
REQ-014 count  output  log2(DEPTH)+1  current occupancy.
REQ-015 mispredict_cnt  output  CNT_W  saturating misprediction total.
REQ-016 overflow_err  output  1  sticky: push attempted while full.
REQ-017 underflow_err  output  1  sticky: resolve attempted while empty.

Function
REQ-018 Storage SHALL be a circular buffer of DEPTH 1-bit predicted directions with write pointer, read pointer, and occupancy counter; pointers wrap modulo DEPTH.
REQ-019 Push: pred_valid=1 and (not full, or resolve accepted the same cycle) -> pred_taken written at write pointer, write pointer +1.
REQ-020 Push while full with no accepted resolve -> prediction dropped, no state change, overflow_err set.
REQ-021 Resolve: resolve_valid=1 and not empty -> head entry read and compared with resolve_taken, read pointer +1.
REQ-022 Resolve while empty -> ignored, no output pulse, underflow_err set; a same-cycle push still accepted (no bypass).
REQ-023 result SHALL assert exactly one cycle, the cycle after an accepted resolve; taken SHALL equal the registered resolve_taken in that cycle and hold its last value otherwise.
REQ-024 mispredict SHALL assert in the same cycle as result iff head entry != resolve_taken.
REQ-025 On a mispredicting resolve, all younger entries are wrong-path: queue SHALL be flushed (pointers equal, count 0) at that edge, and a same-cycle push SHALL be discarded without setting overflow_err.
REQ-026 Correct resolve with simultaneous push: count unchanged; with push only: count +1; with resolve only: count -1.
REQ-027 mispredict_cnt SHALL increment by 1 per mispredict and saturate at 2^CNT_W-1 (no wrap).
REQ-028 overflow_err and underflow_err SHALL remain set until reset.
REQ-029 full, empty, count SHALL be derived from registered occupancy only (no input-to-output combinational path).

Reset
REQ-030 rst=1 SHALL immediately clear pointers, count, result, taken, mispredict, mispredict_cnt, overflow_err, underflow_err; empty=1, full=0.
REQ-031 rst asserted mid-operation SHALL discard all queued predictions; no result pulse SHALL follow the reset release for a resolve issued before it.
REQ-032 First push is accepted on the first rising clk edge with rst=0.

Verification
REQ-033 Push 1,0,1 then resolve 1,0,1 one per cycle -> three result pulses, taken=1,0,1, mispredict never set, count returns to 0, mispredict_cnt=0.
REQ-034 Push 1,1,0; resolve 0 -> one result with taken=0, mispredict=1, count=0 next cycle, mispredict_cnt=1; a later resolve sets underflow_err.
REQ-035 Push 5 times with DEPTH=4, no resolves -> full=1 after 4th, overflow_err=1 after 5th, count=4; then 4 correct resolves drain in order.
REQ-036 Full queue, push and correct resolve same cycle -> count stays 4, overflow_err=0, pushed value emerges after the other three.
REQ-037 Force 260 mispredicts with CNT_W=8 -> mispredict_cnt holds 255.
REQ-038 Assert rst asynchronously between edges with count=3 -> count=0, empty=1, errors cleared before next edge; no stale result after release.
